// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles every signal exchanged between the pipeline datapath and the
// hazard controller.
//   slave  modport : hazard_ctrl (consumes pipeline status, drives controls)
//   master modport : datapath side (drives status, consumes controls)
// Status (master -> slave):
//   rs1D/rs2D          sources of the D instruction
//   rs1E/rs2E/rdE      sources / destination of the E instruction
//   rdM/rdW            destinations in M / W
//   reg_writeM/W       M / W instruction writes the register file
//   loadE, muldivE     E instruction is a load / multi-cycle mul-div
//   pc_srcE            taken branch or jump resolved in E
//   imem_ready         instruction memory data valid this cycle
//   dmem_reqM          M instruction accesses data memory
//   dmem_ready         data memory completes the M access this cycle
// Controls (slave -> master):
//   enF..enW           register enables (PC, D, E, M, W)
//   clrD..clrW         synchronous bubble insert, overrides enable
//   fwdAE/fwdBE        E operand select: 00 regfile, 01 W result, 10 M ALU
//   dbg_state_o        controller FSM state (0 RUN, 1 MDIV, 2 DWAIT)
//   dbg_cnt_o          mul/div down-counter
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REGW       = 5,
  parameter int MULDIV_LAT = 4
);
  localparam int CW = $clog2(MULDIV_LAT);

  logic [REGW-1:0] rs1D, rs2D;
  logic [REGW-1:0] rs1E, rs2E, rdE;
  logic [REGW-1:0] rdM, rdW;
  logic            reg_writeM, reg_writeW;
  logic            loadE, muldivE, pc_srcE;
  logic            imem_ready, dmem_reqM, dmem_ready;

  logic            enF, enD, enE, enM, enW;
  logic            clrD, clrE, clrM, clrW;
  logic [1:0]      fwdAE, fwdBE;

  logic [1:0]      dbg_state_o;
  logic [CW-1:0]   dbg_cnt_o;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output reg_writeM, reg_writeW, loadE, muldivE, pc_srcE,
    output imem_ready, dmem_reqM, dmem_ready,
    input  enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW,
    input  fwdAE, fwdBE, dbg_state_o, dbg_cnt_o
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  reg_writeM, reg_writeW, loadE, muldivE, pc_srcE,
    input  imem_ready, dmem_reqM, dmem_ready,
    output enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW,
    output fwdAE, fwdBE, dbg_state_o, dbg_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RISC-V core. Single source of
// every stall / flush decision plus the E-stage operand forwarding selects.
// Ports:
//   clk      core clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   hz       hazard_ctrl_if.slave (status in, enables/clears/forwarding out)
// Parameters:
//   MULDIV_LAT  cycles a mul/div occupies E (must be >= 2)
//   REGW        register-address width
//
// Handshakes: a data-memory transfer completes on a cycle where
// dmem_reqM && dmem_ready; until then the M instruction is held (F..M frozen)
// and bubbles go to W. An instruction fetch is valid on a cycle where
// imem_ready is high; otherwise F holds and D receives a bubble. Neither
// ready signal is required to wait for anything from this block.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int REGW       = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_ctrl_if.slave hz
);

  localparam int              CW       = $clog2(MULDIV_LAT);
  localparam logic [CW-1:0]   CNT_INIT = CW'(MULDIV_LAT - 2);
  localparam logic [REGW-1:0] X0       = '0;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] MDIV  = 2'd1;
  localparam logic [1:0] DWAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic in_run, in_mdiv, in_dwait;
  logic dmem_stall, mdiv_start, mdiv_stall, branch, load_use;

  logic en_f, en_d, en_e, en_m, en_w;
  logic clr_d, clr_e, clr_m, clr_w;
  logic [1:0] fwd_a, fwd_b;

  assign in_run   = (state_q == RUN);
  assign in_mdiv  = (state_q == MDIV);
  assign in_dwait = (state_q == DWAIT);

  // dmem_reqM only matters in RUN: in MDIV the M stage holds bubbles, and in
  // DWAIT the pending access is already latched into the state.
  assign dmem_stall = (in_run && hz.dmem_reqM && !hz.dmem_ready) ||
                      (in_dwait && !hz.dmem_ready);

  // A mul/div can start from RUN or on the DWAIT release cycle (a mul/div
  // that was blocked by the memory wait begins counting only then).
  assign mdiv_start = (in_run || in_dwait) && hz.muldivE && !dmem_stall;
  assign mdiv_stall = mdiv_start || (in_mdiv && (cnt_q != '0));

  // A branch is only taken when E actually advances this cycle.
  assign branch   = hz.pc_srcE && !dmem_stall && !mdiv_stall;
  assign load_use = hz.loadE && (hz.rdE != X0) &&
                    ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  // Stall / flush outputs, highest-priority hazard first. Reset forces the
  // defaults combinationally so the pipeline sees them as soon as reset_n drops.
  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    clr_d = 1'b0;
    clr_e = 1'b0;
    clr_m = 1'b0;
    clr_w = 1'b0;
    if (!reset_n) begin
      en_f = 1'b1;
    end else if (dmem_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
      clr_w = 1'b1;
    end else if (mdiv_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      clr_m = 1'b1;
    end else if (branch) begin
      // PC keeps loading so the target is fetched; this also overrides a
      // simultaneous load-use or fetch wait.
      clr_d = 1'b1;
      clr_e = 1'b1;
    end else if (load_use) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end else if (!hz.imem_ready) begin
      en_f  = 1'b0;
      clr_d = 1'b1;
    end
  end

  // Forwarding: the younger producer in M wins over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs,
                                         input logic            wr_m,
                                         input logic [REGW-1:0] rd_m,
                                         input logic            wr_w,
                                         input logic [REGW-1:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != X0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != X0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a = reset_n ? fwd_sel(hz.rs1E, hz.reg_writeM, hz.rdM, hz.reg_writeW, hz.rdW) : 2'b00;
  assign fwd_b = reset_n ? fwd_sel(hz.rs2E, hz.reg_writeM, hz.rdM, hz.reg_writeW, hz.rdW) : 2'b00;

  // Next state. cnt counts the remaining mul/div stall cycles after the
  // first one, so MDIV with cnt == 0 is the release cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (dmem_stall) begin
          state_d = DWAIT;
        end else if (mdiv_start) begin
          state_d = MDIV;
          cnt_d   = CNT_INIT;
        end
      end
      MDIV: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RUN;
        end
      end
      DWAIT: begin
        if (!dmem_stall) begin
          if (mdiv_start) begin
            state_d = MDIV;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.enF        = en_f;
  assign hz.enD        = en_d;
  assign hz.enE        = en_e;
  assign hz.enM        = en_m;
  assign hz.enW        = en_w;
  assign hz.clrD       = clr_d;
  assign hz.clrE       = clr_e;
  assign hz.clrM       = clr_m;
  assign hz.clrW       = clr_w;
  assign hz.fwdAE      = fwd_a;
  assign hz.fwdBE      = fwd_b;
  assign hz.dbg_state_o = state_q;
  assign hz.dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. Output word layout used throughout:
//   {enF,enD,enE,enM,enW, clrD,clrE,clrM,clrW, fwdAE, fwdBE}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int LAT  = 4;
  localparam int REGW = 5;
  localparam int CW   = $clog2(LAT);

  localparam int ST_RUN   = 0;
  localparam int ST_MDIV  = 1;
  localparam int ST_DWAIT = 2;

  // Expected stall / flush patterns (forwarding bits 00)
  localparam logic [12:0] DEF   = 13'b11111_0000_0000;
  localparam logic [12:0] S_DM  = 13'b00001_0001_0000;
  localparam logic [12:0] S_MUL = 13'b00011_0010_0000;
  localparam logic [12:0] S_BR  = 13'b11111_1100_0000;
  localparam logic [12:0] S_LU  = 13'b00111_0100_0000;
  localparam logic [12:0] S_IM  = 13'b01111_1000_0000;

  typedef struct {
    logic [REGW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic reg_writeM, reg_writeW, loadE, muldivE, pc_srcE;
    logic imem_ready, dmem_reqM, dmem_ready;
  } in_t;

  typedef struct {
    in_t         i;
    logic [12:0] e;
    string       nm;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  hazard_ctrl_if #(.REGW(REGW), .MULDIV_LAT(LAT)) hz ();

  hazard_ctrl #(.MULDIV_LAT(LAT), .REGW(REGW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .hz     (hz)
  );

  // ---------------- scoreboard state ----------------
  int unsigned n_cmp;
  int unsigned n_bad;
  logic [12:0] exp_q[$];
  vec_t        tbl[$];
  in_t         cur_in;

  // ---------------- reference model ----------------
  // m_age: cycles the current mul/div has already spent stalled in E
  // (0 = none in progress). m_dw: a data access is still outstanding.
  int unsigned m_age, m_age_n;
  bit          m_dw, m_dw_n;

  function automatic logic [1:0] fwd_ref(input logic [REGW-1:0] rs, input in_t v);
    if (v.reg_writeM && v.rdM != 0 && v.rdM == rs) return 2'b10;
    if (v.reg_writeW && v.rdW != 0 && v.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] model_eval(input in_t v, input logic rn);
    logic [4:0] en;
    logic [3:0] clr;
    bit dst, mst, br, lu;
    en      = 5'b11111;
    clr     = 4'b0000;
    m_age_n = m_age;
    m_dw_n  = m_dw;
    if (!rn) begin
      m_age_n = 0;
      m_dw_n  = 0;
      return {en, clr, 4'b0000};
    end
    dst = (m_age == 0) && !v.dmem_ready && (m_dw || v.dmem_reqM);
    mst = !dst && ((m_age > 0) ? (m_age < LAT - 1) : v.muldivE);
    br  = v.pc_srcE && !dst && !mst;
    lu  = v.loadE && v.rdE != 0 && (v.rdE == v.rs1D || v.rdE == v.rs2D);
    if (dst)                begin en = 5'b00001; clr = 4'b0001; end
    else if (mst)           begin en = 5'b00011; clr = 4'b0010; end
    else if (br)            begin en = 5'b11111; clr = 4'b1100; end
    else if (lu)            begin en = 5'b00111; clr = 4'b0100; end
    else if (!v.imem_ready) begin en = 5'b01111; clr = 4'b1000; end
    m_dw_n = dst;
    if (m_age > 0)  m_age_n = (m_age < LAT - 1) ? m_age + 1 : 0;
    else if (mst)   m_age_n = 1;
    return {en, clr, fwd_ref(v.rs1E, v), fwd_ref(v.rs2E, v)};
  endfunction

  // ---------------- driver tasks ----------------
  function automatic in_t base();
    in_t v;
    v.rs1D = '0; v.rs2D = '0; v.rs1E = '0; v.rs2E = '0;
    v.rdE  = '0; v.rdM  = '0; v.rdW  = '0;
    v.reg_writeM = 1'b0; v.reg_writeW = 1'b0;
    v.loadE = 1'b0; v.muldivE = 1'b0; v.pc_srcE = 1'b0;
    v.imem_ready = 1'b1; v.dmem_reqM = 1'b0; v.dmem_ready = 1'b1;
    return v;
  endfunction

  task automatic drive(input in_t v);
    cur_in        = v;
    hz.rs1D       = v.rs1D;
    hz.rs2D       = v.rs2D;
    hz.rs1E       = v.rs1E;
    hz.rs2E       = v.rs2E;
    hz.rdE        = v.rdE;
    hz.rdM        = v.rdM;
    hz.rdW        = v.rdW;
    hz.reg_writeM = v.reg_writeM;
    hz.reg_writeW = v.reg_writeW;
    hz.loadE      = v.loadE;
    hz.muldivE    = v.muldivE;
    hz.pc_srcE    = v.pc_srcE;
    hz.imem_ready = v.imem_ready;
    hz.dmem_reqM  = v.dmem_reqM;
    hz.dmem_ready = v.dmem_ready;
  endtask

  // Advance one clock: the model's next state is taken from the inputs held
  // during the cycle, committed at the edge; returns 1 time unit after it.
  task automatic tick();
    void'(model_eval(cur_in, reset_n));
    @(posedge clk);
    m_age = m_age_n;
    m_dw  = m_dw_n;
    #1;
  endtask

  function automatic logic [12:0] actual();
    return {hz.enF, hz.enD, hz.enE, hz.enM, hz.enW,
            hz.clrD, hz.clrE, hz.clrM, hz.clrW, hz.fwdAE, hz.fwdBE};
  endfunction

  task automatic check_vec(input logic [12:0] e, input string nm);
    logic [12:0] a;
    a = actual();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (enF..W clrD..W fwdA fwdB)", nm, a, e);
    end
  endtask

  task automatic check_int(input int a, input int e, input string nm);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, a, e);
    end
  endtask

  // drive at edge+1, compare mid-cycle, then clock
  task automatic run(input in_t v, input logic [12:0] e, input string nm);
    drive(v);
    #4;
    check_vec(e, nm);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    in_t v;
    n_cmp   = 0;
    n_bad   = 0;
    m_age   = 0;
    m_dw    = 0;
    reset_n = 1'b0;
    drive(base());
    tick();
    tick();

    // Reset holds defaults even with every hazard present on the inputs
    v = base();
    v.loadE = 1'b1; v.rdE = 5'd3; v.rs1D = 5'd3; v.pc_srcE = 1'b1;
    v.muldivE = 1'b1; v.dmem_reqM = 1'b1; v.dmem_ready = 1'b0; v.imem_ready = 1'b0;
    v.rs1E = 5'd4; v.rdM = 5'd4; v.reg_writeM = 1'b1;
    drive(v);
    #4;
    check_vec(DEF, "reset_outputs");
    check_int(int'(hz.dbg_state_o), ST_RUN, "reset_state");
    check_int(int'(hz.dbg_cnt_o), 0, "reset_cnt");
    drive(base());
    tick();
    reset_n = 1'b1;

    // ---------- table-driven single-cycle vectors (state stays RUN) ----------
    v = base(); v.rs1E = 5'd5; v.rdM = 5'd5; v.reg_writeM = 1'b1; v.rdW = 5'd5; v.reg_writeW = 1'b1;
    tbl.push_back('{v, 13'b11111_0000_1000, "fwdA_m_over_w"});
    v = base(); v.rs1E = 5'd5; v.rdM = 5'd0; v.reg_writeM = 1'b1; v.rdW = 5'd5; v.reg_writeW = 1'b1;
    tbl.push_back('{v, 13'b11111_0000_0100, "fwdA_w_rdm0"});
    v = base(); v.rs1E = 5'd5; v.rdM = 5'd5; v.rdW = 5'd5;
    tbl.push_back('{v, DEF, "fwdA_disabled"});
    v = base(); v.rs1E = 5'd6; v.rs2E = 5'd7; v.rdM = 5'd6; v.reg_writeM = 1'b1; v.rdW = 5'd7; v.reg_writeW = 1'b1;
    tbl.push_back('{v, 13'b11111_0000_1001, "fwd_a_m_b_w"});
    v = base(); v.rs2E = 5'd9; v.rdM = 5'd9; v.reg_writeM = 1'b1;
    tbl.push_back('{v, 13'b11111_0000_0010, "fwdB_m"});
    v = base(); v.rs1E = 5'd0; v.rdW = 5'd0; v.reg_writeW = 1'b1;
    tbl.push_back('{v, DEF, "fwd_x0_never"});
    v = base(); v.loadE = 1'b1; v.rdE = 5'd3; v.rs2D = 5'd3;
    tbl.push_back('{v, S_LU, "load_use_rs2"});
    v = base();
    tbl.push_back('{v, DEF, "after_load_use"});
    v = base(); v.loadE = 1'b1; v.rdE = 5'd0; v.rs1D = 5'd0;
    tbl.push_back('{v, DEF, "load_use_rd0"});
    v = base(); v.loadE = 1'b1; v.rdE = 5'd3; v.rs1D = 5'd4; v.rs2D = 5'd5;
    tbl.push_back('{v, DEF, "load_no_dep"});
    v = base(); v.rdE = 5'd3; v.rs1D = 5'd3;
    tbl.push_back('{v, DEF, "non_load_dep"});
    v = base(); v.pc_srcE = 1'b1;
    tbl.push_back('{v, S_BR, "branch"});
    v = base(); v.pc_srcE = 1'b1; v.loadE = 1'b1; v.rdE = 5'd3; v.rs1D = 5'd3;
    tbl.push_back('{v, S_BR, "branch_over_load_use"});
    v = base(); v.imem_ready = 1'b0;
    tbl.push_back('{v, S_IM, "imem_wait"});
    v = base(); v.pc_srcE = 1'b1; v.imem_ready = 1'b0;
    tbl.push_back('{v, S_BR, "branch_with_imem_wait"});
    v = base(); v.loadE = 1'b1; v.rdE = 5'd2; v.rs1D = 5'd2; v.imem_ready = 1'b0;
    tbl.push_back('{v, S_LU, "load_use_over_imem"});
    v = base(); v.dmem_reqM = 1'b1; v.dmem_ready = 1'b1;
    tbl.push_back('{v, DEF, "dmem_zero_wait"});

    for (int k = 0; k < tbl.size(); k++) begin
      run(tbl[k].i, tbl[k].e, tbl[k].nm);
    end

    // ---------- mul/div held for LAT cycles ----------
    v = base(); v.muldivE = 1'b1;
    for (int k = 0; k < LAT - 1; k++) run(v, S_MUL, "muldiv_stall");
    run(v, DEF, "muldiv_release");
    check_int(int'(hz.dbg_state_o), ST_RUN, "muldiv_back_to_run");

    // ---------- dmem wait, 2 wait cycles ----------
    v = base(); v.dmem_reqM = 1'b1; v.dmem_ready = 1'b0;
    run(v, S_DM, "dmem_wait_1");
    check_int(int'(hz.dbg_state_o), ST_DWAIT, "dmem_in_dwait");
    run(v, S_DM, "dmem_wait_2");
    v.dmem_ready = 1'b1;
    run(v, DEF, "dmem_release");
    check_int(int'(hz.dbg_state_o), ST_RUN, "dmem_back_to_run");

    // ---------- dmem miss with mul/div in E ----------
    v = base(); v.muldivE = 1'b1; v.dmem_reqM = 1'b1; v.dmem_ready = 1'b0;
    run(v, S_DM, "dm_mul_wait_1");
    run(v, S_DM, "dm_mul_wait_2");
    v.dmem_ready = 1'b1;
    run(v, S_MUL, "dm_mul_release_starts_mdiv");
    check_int(int'(hz.dbg_state_o), ST_MDIV, "dm_mul_in_mdiv");
    check_int(int'(hz.dbg_cnt_o), LAT - 2, "dm_mul_cnt_init");
    v.dmem_ready = 1'b0;
    run(v, S_MUL, "mdiv_ignores_dmem");
    v.dmem_reqM = 1'b0;
    run(v, S_MUL, "dm_mul_stall_3");
    run(v, DEF, "dm_mul_release");

    // ---------- branch pending in E during MDIV ----------
    v = base(); v.muldivE = 1'b1;
    run(v, S_MUL, "br_mdiv_start");
    v.pc_srcE = 1'b1;
    run(v, S_MUL, "br_mdiv_held_1");
    run(v, S_MUL, "br_mdiv_held_2");
    run(v, S_BR, "br_mdiv_release");

    // ---------- branch pending in E during DWAIT ----------
    v = base(); v.pc_srcE = 1'b1; v.dmem_reqM = 1'b1; v.dmem_ready = 1'b0;
    run(v, S_DM, "br_dwait_held");
    v.dmem_ready = 1'b1;
    run(v, S_BR, "br_dwait_release");

    // ---------- reset in MDIV with cnt = 1 ----------
    v = base(); v.muldivE = 1'b1;
    run(v, S_MUL, "rst_mdiv_1");
    run(v, S_MUL, "rst_mdiv_2");
    drive(v);
    #4;
    check_vec(S_MUL, "rst_mdiv_3");
    check_int(int'(hz.dbg_cnt_o), 1, "rst_mdiv_cnt1");
    reset_n = 1'b0;
    m_age   = 0;
    m_dw    = 0;
    #1;
    check_vec(DEF, "rst_async_defaults");
    check_int(int'(hz.dbg_state_o), ST_RUN, "rst_async_state");
    check_int(int'(hz.dbg_cnt_o), 0, "rst_async_cnt");
    #1;
    reset_n = 1'b1;
    #1;
    check_vec(S_MUL, "rst_release_muldiv");
    tick();
    check_int(int'(hz.dbg_state_o), ST_MDIV, "rst_restart_state");
    check_int(int'(hz.dbg_cnt_o), LAT - 2, "rst_restart_cnt");
    run(v, S_MUL, "rst_restart_stall_2");
    run(v, S_MUL, "rst_restart_stall_3");
    run(v, DEF, "rst_restart_release");

    // ---------- randomized stimulus against the reference model ----------
    drive(base());
    tick();
    for (int k = 0; k < 400; k++) begin
      v.rs1D       = REGW'($urandom_range(0, 3));
      v.rs2D       = REGW'($urandom_range(0, 3));
      v.rs1E       = REGW'($urandom_range(0, 3));
      v.rs2E       = REGW'($urandom_range(0, 3));
      v.rdE        = REGW'($urandom_range(0, 3));
      v.rdM        = REGW'($urandom_range(0, 3));
      v.rdW        = REGW'($urandom_range(0, 3));
      v.reg_writeM = ($urandom_range(0, 1) == 1);
      v.reg_writeW = ($urandom_range(0, 1) == 1);
      v.loadE      = ($urandom_range(0, 9) < 3);
      v.muldivE    = ($urandom_range(0, 9) < 1);
      v.pc_srcE    = ($urandom_range(0, 19) < 3);
      v.imem_ready = ($urandom_range(0, 9) < 8);
      v.dmem_reqM  = ($urandom_range(0, 9) < 3);
      v.dmem_ready = ($urandom_range(0, 9) < 6);
      reset_n      = ($urandom_range(0, 59) != 0);
      exp_q.push_back(model_eval(v, reset_n));
      drive(v);
      #4;
      check_vec(exp_q.pop_front(), "random");
      tick();
      reset_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
